// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: runs one full-subtractor cell LSB first over WIDTH cycles
// and computes a - b - bin, with a start/busy/done handshake.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    // Bit 0 of the working result would be shifted out unread, so only the
    // upper WIDTH-1 bits are stored; the final shift is taken straight into diff.
    logic [WIDTH-1:1] sd;
    logic             bf;
    logic [CW-1:0]    cnt;
    logic             d, bo;
    logic [WIDTH-1:0] sd_shift;

    assign d        = sa[0] ^ sb[0] ^ bf;
    assign bo       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
    assign sd_shift = {d, sd};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            bf   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            borr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bf  <= bin;
                        sd  <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sd  <= sd_shift[WIDTH-1:1];
                    bf  <= bo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff <= sd_shift;
                        borr <= bo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: vector table, handshake timing, corner
// sequences, and back-to-back runs on WIDTH=8 and WIDTH=2 instances.
module tb_serial_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, borr;
    logic [7:0] diff;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       bin2 = 1'b0;
    logic       busy2, done2, borr2;
    logic [1:0] diff2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .borr(borr)
    );

    serial_sub_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borr(borr2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One isolated operation on the WIDTH=8 instance, with handshake timing checks.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic eb, input string name);
        int n, nbusy;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ia; b = ~ib; bin = ~ibin;
        n = 0;
        nbusy = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
        check({name, " latency"}, n, 8);
        check({name, " busy_cycles"}, nbusy, 9);
        check({name, " diff"}, diff, ed);
        check({name, " borr"}, borr, eb);
        @(negedge clk);
        check({name, " done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [8:0] ref9;
        logic [2:0] ref3;
        logic [7:0] ra, rb;
        logic       rbin;
        int         n;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'hA7, 8'hA7, 1'b0, 8'h00, 1'b0};

        #2;
        check("reset_outputs", {busy, done, borr, diff}, 11'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));

        // start pulse mid-operation is ignored; operand changes have no effect
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hC3; b = 8'h99; bin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_start latency", n, 8);
        check("busy_start diff", diff, 8'h1E);
        check("busy_start borr", borr, 1'b0);
        @(negedge clk);
        check("busy_start no_requeue", {busy, done}, 2'b00);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset outputs", {busy, done, borr, diff}, 11'h0);
        @(negedge clk);
        check("midop_reset held", {busy, done, borr, diff}, 11'h0);
        rst_n = 1'b1;
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "post_reset");

        // back-to-back WIDTH=8 with start held high, checked against a - b - bin
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        a = ra; b = rb; bin = rbin; start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'h0, rbin};
            for (int off = 0; off <= 9; off++) begin
                @(negedge clk);
                if (off == 1) begin
                    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
                end
                if (off == 7) check("b2b8 early_done", done, 1'b0);
                if (off == 8) begin
                    check("b2b8 done", done, 1'b1);
                    check("b2b8 result", {borr, diff}, ref9);
                end
                if (off == 9) begin
                    check("b2b8 idle_gap", {busy, done}, 2'b00);
                    if (k == 15) start = 1'b0;
                    else begin
                        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
                        a = ra; b = rb; bin = rbin;
                    end
                end
            end
        end

        // WIDTH=2: sweep all 32 a/b/bin combinations back-to-back
        @(negedge clk);
        {a2, b2, bin2} = 5'd0;
        start2 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ref3 = {1'b0, a2} - {1'b0, b2} - {2'b0, bin2};
            for (int off = 0; off <= 3; off++) begin
                @(negedge clk);
                if (off == 0) begin
                    check("w2 busy", busy2, 1'b1);
                    {a2, b2, bin2} = ~5'(k);
                end
                if (off == 2) begin
                    check("w2 done", done2, 1'b1);
                    check($sformatf("w2 result k=%0d", k), {borr2, diff2}, ref3);
                end
                if (off == 3) begin
                    check("w2 idle_gap", {busy2, done2}, 2'b00);
                    if (k == 31) start2 = 1'b0;
                    else {a2, b2, bin2} = 5'(k + 1);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
